transmisor_uart: RTL and testbench
==================================

// Module: transmisor_uart
// PURPOSE
//  Serial UART transmitter directly downstream of the status-packet encoder.
//  Captures each byte the encoder presents (datotx + init strobe) and shifts it out on tx.
//  Frame format: 1 start bit, 8 data bits LSB first, 1 stop bit.
//  A one-byte holding register absorbs a byte that arrives while a frame is still on the line.
// PARAMETERS
//  CLKS_PER_BIT  1  clkBaud cycles per serial bit (1 = clkBaud is the bit clock)
//  SAMPLE_DELAY  1  cycles after init rises before datotx is sampled (encoder updates datotx one cycle after init)
// PORTS
//  clkBaud    in   1  baud clock; all logic on posedge
//  nReset     in   1  asynchronous, active-low reset
//  init       in   1  byte-available strobe from encoder; rising edge is significant
//  datotx     in   8  byte to send; valid SAMPLE_DELAY cycles after init rises
//  tx         out  1  serial line, idle high
//  busy       out  1  high while a frame is on the line or the holding register is full
//  frameDone  out  1  one-cycle pulse in the final stop-bit cycle of each frame
//  overrun    out  1  sticky drop flag (only with TX_OVERRUN_EN)
// BEHAVIOUR
//  Reset: tx=1, busy=0, frameDone=0, overrun=0; FSM=IDLE; holding empty; counters 0; init edge register 0.
//  Strobe: initPrev registered; rise = init & ~initPrev; a held-high init is one request only.
//  Capture: delay counter loads SAMPLE_DELAY on rise; datotx is sampled when it reaches 0 (SAMPLE_DELAY=0: same cycle as rise).
//   A new rise during the countdown restarts it; the earlier request is lost and counts as an overrun.
//  Captured byte goes to the holding register (holdFull=1). If holdFull is already 1, the byte is dropped and the holding content is kept.
//  FSM: IDLE -> START when holdFull; the shift register loads from holding and holdFull clears in the same cycle.
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA: tx=shift[0], shift right every CLKS_PER_BIT cycles; 3-bit bit index 0..7; after bit 7 -> STOP.
//   STOP: tx=1 for CLKS_PER_BIT cycles; frameDone pulses in the last cycle.
//    Then -> START if holdFull (back-to-back frames, no idle bit), else -> IDLE.
//  Capture into holding is allowed in any FSM state. Capture and transfer in the same cycle: transfer takes the old content, the new byte fills holding.
//  Latency: SAMPLE_DELAY = 1 from an idle line gives init rise at T, sample at T+1, START at T+2, i.e. tx falls 2 cycles after init rises.
//  Bit counter width: $clog2(CLKS_PER_BIT) bits, minimum 1; wraps to 0 at CLKS_PER_BIT-1.
//  busy = (FSM != IDLE) | holdFull.
//  Reset mid-frame: tx returns to 1 immediately (async); the partial frame is abandoned and no frameDone is issued.
// CONFIGURATION
//  TX_OVERRUN_EN defined: overrun is set on any dropped byte (holding full at capture, or capture countdown restarted).
//   It stays 1 until nReset.
//  TX_OVERRUN_EN undefined: overrun port is tied 0 and the drop logic is removed. Drops still occur silently.
// STRUCTURE
//  Shared package/header uart_pkg: FSM state encodings (IDLE, START, DATA, STOP), START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LINE=1'b1, DATA_BITS=8.
//   The encoder and a future receiver share these constants.
//  One natural sub-module: uart_bit_timer (CLKS_PER_BIT tick generator: inputs clkBaud, nReset, run; output tick).
//  Everything else stays inline.
// TESTING
//  1. Reset, idle 5 cycles -> tx=1, busy=0, frameDone=0 throughout.
//  2. init rise at T, datotx=8'hB1 at T+1 -> tx from T+2: 0,1,0,0,0,1,1,0,1,1; frameDone at T+11; busy low at T+12.
//  3. Encoder cadence, init every 16 cycles, bytes 8'h33 then 8'h30 -> two clean frames with idle gap; overrun=0.
//  4. Second init 3 cycles after the first (8'h31 then 8'hB1) -> 8'hB1 held, sent back-to-back: its start bit follows the first stop bit with no gap.
//  5. Three inits within one frame (TX_OVERRUN_EN) -> third byte dropped, overrun=1 and sticky; first two bytes sent intact.
//  6. nReset low during DATA bit 4 -> tx=1 asynchronously, busy=0; the next init produces a complete fresh frame.
//  7. CLKS_PER_BIT=4 build, byte 8'h55 -> each bit held 4 cycles, frame = 40 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and FSM encoding, used by the transmitter, the status encoder and the future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/transmisor_uart_if.sv
// Encoder-to-transmitter link: byte strobe and data in, serial line and status out.
interface transmisor_uart_if;
  logic       init;
  logic [7:0] datotx;
  logic       tx;
  logic       busy;
  logic       frameDone;
  logic       overrun;

  modport master (
    output init, datotx,
    input  tx, busy, frameDone, overrun
  );

  modport slave (
    input  init, datotx,
    output tx, busy, frameDone, overrun
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period tick generator: tick is high in the last clkBaud cycle of every serial bit while run is high.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clkBaud,
  input  logic nReset,
  input  logic run,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Held at 0 while stopped so the first bit after start is a full period.
  always_ff @(posedge clkBaud or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == LAST);
endmodule

// File: rtl/transmisor_uart.sv
// UART transmitter (8N1, LSB first) with a one-byte holding register behind the status-packet encoder.
// Build option TX_OVERRUN_EN: sticky overrun flag on dropped bytes; otherwise overrun is tied low.
module transmisor_uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SAMPLE_DELAY = 1
) (
  input  logic               clkBaud,
  input  logic               nReset,
  transmisor_uart_if.slave   bus
);
  uartState_t state;
  logic       initPrev;
  logic       rise;
  logic       sampleNow;
  logic       holdFull;
  logic [7:0] holdData;
  logic [7:0] shiftReg;
  logic [2:0] bitIdx;
  logic       txReg;
  logic       tick;
  logic       timerRun;
  logic       loadShift;
  logic       captureEn;
  logic       shiftEn;
`ifdef TX_OVERRUN_EN
  logic       restartDrop;
  logic       overrunReg;
`endif

  assign rise = bus.init & ~initPrev;

  generate
    if (SAMPLE_DELAY == 0) begin : gNoDelay
      assign sampleNow = rise;
`ifdef TX_OVERRUN_EN
      assign restartDrop = 1'b0;
`endif
    end else begin : gDelay
      localparam int DW = (SAMPLE_DELAY > 1) ? $clog2(SAMPLE_DELAY) : 1;
      logic [DW-1:0] dlyCnt;
      logic          dlyPend;

      // A rise during an open countdown restarts it; the older request is abandoned.
      always_ff @(posedge clkBaud or negedge nReset) begin
        if (!nReset) begin
          dlyCnt  <= '0;
          dlyPend <= 1'b0;
        end else if (rise) begin
          dlyCnt  <= DW'(SAMPLE_DELAY - 1);
          dlyPend <= 1'b1;
        end else if (dlyPend) begin
          if (dlyCnt == '0) dlyPend <= 1'b0;
          else              dlyCnt  <= dlyCnt - 1'b1;
        end
      end

      assign sampleNow = dlyPend && (dlyCnt == '0) && !rise;
`ifdef TX_OVERRUN_EN
      assign restartDrop = dlyPend && rise;
`endif
    end
  endgenerate

  assign timerRun  = (state != IDLE);
  assign loadShift = holdFull && ((state == IDLE) || (state == STOP && tick));
  // A byte arriving as holding empties into the shifter is kept, not dropped.
  assign captureEn = sampleNow && (!holdFull || loadShift);
  assign shiftEn   = (state == DATA) && tick;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) uTimer (
    .clkBaud (clkBaud),
    .nReset  (nReset),
    .run     (timerRun),
    .tick    (tick)
  );

  always_ff @(posedge clkBaud or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      txReg    <= IDLE_LINE;
      bitIdx   <= '0;
      holdFull <= 1'b0;
      initPrev <= 1'b0;
    end else begin
      initPrev <= bus.init;
      if (captureEn)      holdFull <= 1'b1;
      else if (loadShift) holdFull <= 1'b0;

      case (state)
        IDLE: begin
          if (holdFull) begin
            state <= START;
            txReg <= START_BIT;
          end
        end
        START: begin
          if (tick) begin
            state  <= DATA;
            txReg  <= shiftReg[0];
            bitIdx <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bitIdx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              txReg <= STOP_BIT;
            end else begin
              bitIdx <= bitIdx + 1'b1;
              txReg  <= shiftReg[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (holdFull) begin
              state <= START;
              txReg <= START_BIT;
            end else begin
              state <= IDLE;
              txReg <= IDLE_LINE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte storage carries no reset; holdFull and the FSM qualify its contents.
  always_ff @(posedge clkBaud) begin
    if (captureEn) holdData <= bus.datotx;
    if (loadShift)    shiftReg <= holdData;
    else if (shiftEn) shiftReg <= {1'b0, shiftReg[7:1]};
  end

`ifdef TX_OVERRUN_EN
  always_ff @(posedge clkBaud or negedge nReset) begin
    if (!nReset) begin
      overrunReg <= 1'b0;
    end else if ((sampleNow && holdFull && !loadShift) || restartDrop) begin
      overrunReg <= 1'b1;
    end
  end
  assign bus.overrun = overrunReg;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.tx        = txReg;
  assign bus.busy      = (state != IDLE) | holdFull;
  assign bus.frameDone = (state == STOP) && tick;
endmodule

// File: tb/tb_transmisor_uart.sv
// Directed bench for transmisor_uart: timing checks inline plus a line receiver scoreboard on the 1-clock-per-bit instance.
module tb_transmisor_uart;
  logic clk = 1'b0;
  logic nReset;

  transmisor_uart_if bus1 ();
  transmisor_uart_if bus4 ();

  transmisor_uart #(.CLKS_PER_BIT(1), .SAMPLE_DELAY(1)) dut1 (
    .clkBaud (clk),
    .nReset  (nReset),
    .bus     (bus1)
  );

  transmisor_uart #(.CLKS_PER_BIT(4), .SAMPLE_DELAY(1)) dut4 (
    .clkBaud (clk),
    .nReset  (nReset),
    .bus     (bus4)
  );

  always #5 clk = ~clk;

`ifdef TX_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  int passCnt  = 0;
  int totalCnt = 0;
  logic [7:0] expQ [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) begin
      passCnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] frameOf(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // init rises at the next edge T; datotx becomes valid only for edge T+1.
  task automatic sendByte(input logic [7:0] b, input bit keep);
    bus1.init   = 1'b1;
    bus1.datotx = ~b;
    step();
    bus1.datotx = b;
    bus1.init   = 1'b0;
    if (keep) expQ.push_back(b);
    step();
  endtask

  // Reference receiver on the serial line.
  int         rxCnt = 0;
  logic [7:0] rxByte;
  logic [7:0] expB;
  always @(negedge clk) begin
    if (!nReset) begin
      rxCnt = 0;
    end else if (rxCnt == 0) begin
      if (bus1.tx == 1'b0) rxCnt = 1;
    end else if (rxCnt <= 8) begin
      rxByte = {bus1.tx, rxByte[7:1]};
      rxCnt++;
    end else begin
      check("stopBit", {31'b0, bus1.tx}, 32'd1);
      check("frameDoneAtStop", {31'b0, bus1.frameDone}, 32'd1);
      if (expQ.size() != 0) expB = expQ.pop_front();
      else                  expB = ~rxByte;
      check("rxByte", {24'b0, rxByte}, {24'b0, expB});
      rxCnt = 0;
    end
  end

  initial begin
    logic [9:0] fr;
    nReset      = 1'b0;
    bus1.init   = 1'b0;
    bus1.datotx = 8'h00;
    bus4.init   = 1'b0;
    bus4.datotx = 8'h00;
    step();
    check("rstTx", {31'b0, bus1.tx}, 32'd1);
    check("rstBusy", {31'b0, bus1.busy}, 32'd0);
    check("rstOverrun", {31'b0, bus1.overrun}, 32'd0);
    step();
    nReset = 1'b1;

    // Idle line after reset
    for (int i = 0; i < 5; i++) begin
      step();
      check("idleTx", {31'b0, bus1.tx}, 32'd1);
      check("idleBusy", {31'b0, bus1.busy}, 32'd0);
      check("idleFrameDone", {31'b0, bus1.frameDone}, 32'd0);
    end

    // Single frame 0xB1, exact cycle timing
    sendByte(8'hB1, 1'b1);
    fr = frameOf(8'hB1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("b1Tx", {31'b0, bus1.tx}, {31'b0, fr[i]});
      check("b1FrameDone", {31'b0, bus1.frameDone}, {31'b0, (i == 9)});
    end
    step();
    check("b1BusyLow", {31'b0, bus1.busy}, 32'd0);

    // Encoder cadence: two frames with an idle gap
    sendByte(8'h33, 1'b1);
    repeat (14) step();
    check("gapTx", {31'b0, bus1.tx}, 32'd1);
    check("gapBusy", {31'b0, bus1.busy}, 32'd0);
    sendByte(8'h30, 1'b1);
    repeat (14) step();
    check("cadenceBusy", {31'b0, bus1.busy}, 32'd0);
    check("cadenceOverrun", {31'b0, bus1.overrun}, 32'd0);
    check("cadenceQueue", expQ.size(), 32'd0);

    // Back-to-back via the holding register
    sendByte(8'h31, 1'b1);
    step();
    sendByte(8'hB1, 1'b1);
    repeat (7) step();
    check("b2bStopTx", {31'b0, bus1.tx}, 32'd1);
    check("b2bStopDone", {31'b0, bus1.frameDone}, 32'd1);
    check("b2bStopBusy", {31'b0, bus1.busy}, 32'd1);
    step();
    check("b2bStartTx", {31'b0, bus1.tx}, 32'd0);
    check("b2bStartBusy", {31'b0, bus1.busy}, 32'd1);
    check("b2bStartDone", {31'b0, bus1.frameDone}, 32'd0);
    repeat (12) step();
    check("b2bBusyLow", {31'b0, bus1.busy}, 32'd0);

    // Third byte while holding is full gets dropped
    sendByte(8'h41, 1'b1);
    step();
    sendByte(8'h42, 1'b1);
    step();
    sendByte(8'h43, 1'b0);
    check("dropOverrun", {31'b0, bus1.overrun}, {31'b0, OVR_EXP});
    repeat (20) step();
    check("dropBusyLow", {31'b0, bus1.busy}, 32'd0);
    check("dropOverrunSticky", {31'b0, bus1.overrun}, {31'b0, OVR_EXP});
    check("dropQueue", expQ.size(), 32'd0);

    // Reset during data bit 4 (0xA5 bit 4 is 0)
    sendByte(8'hA5, 1'b1);
    repeat (6) step();
    check("midBit4Tx", {31'b0, bus1.tx}, 32'd0);
    #2 nReset = 1'b0;
    #1;
    check("asyncRstTx", {31'b0, bus1.tx}, 32'd1);
    check("asyncRstBusy", {31'b0, bus1.busy}, 32'd0);
    check("asyncRstDone", {31'b0, bus1.frameDone}, 32'd0);
    check("asyncRstOverrun", {31'b0, bus1.overrun}, 32'd0);
    expQ.delete();
    step();
    step();
    nReset = 1'b1;
    step();
    sendByte(8'hC3, 1'b1);
    repeat (14) step();
    check("postRstBusy", {31'b0, bus1.busy}, 32'd0);
    check("postRstQueue", expQ.size(), 32'd0);

    // Four clocks per bit: 0x55 frame spans 40 cycles
    bus4.init   = 1'b1;
    bus4.datotx = 8'hAA;
    step();
    bus4.datotx = 8'h55;
    bus4.init   = 1'b0;
    step();
    fr = frameOf(8'h55);
    for (int i = 0; i < 40; i++) begin
      step();
      check("cpb4Tx", {31'b0, bus4.tx}, {31'b0, fr[i / 4]});
      check("cpb4Done", {31'b0, bus4.frameDone}, {31'b0, (i == 39)});
    end
    step();
    check("cpb4BusyLow", {31'b0, bus4.busy}, 32'd0);
    check("finalQueue", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
